fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage for the RV32IM core, sitting directly upstream of the `Datapath` decode/execute logic. It owns the architectural fetch PC, issues word requests to instruction memory over a valid/ready request channel, buffers in-order responses in a small FIFO, and presents {instruction, PC} pairs to decode with a valid/ready handshake. A redirect from execute (branch/jump) flushes the buffer and discards stale in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 2, instruction FIFO entries (≥2); also the maximum of buffered plus outstanding fetches
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-low (asserted while 0, sampled on `clk` rising edge)
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  word-aligned fetch address
- `imem_rsp_valid`  in  1  response valid; responses return in request order, ≥1 cycle after acceptance, never back-pressured
- `imem_rsp_data`  in  32  fetched instruction word
- `redirect_valid`  in  1  execute redirects fetch this cycle
- `redirect_pc`  in  32  new fetch PC; bits [1:0] ignored (forced to 00)
- `ins_valid`  out  1  instruction available to decode
- `ins_ready`  in  1  decode consumes instruction
- `ins_data`  out  32  instruction word
- `ins_pc`  out  32  address of `ins_data`
- `pc_changed`  out  1  one-cycle pulse when the fetch PC register updates

## Operation
- State: `fetch_pc`, FIFO (`occ` 0..DEPTH), `outstanding` 0..DEPTH, `discard` 0..DEPTH, all `$clog2(DEPTH+1)` bits wide.
- Reset values: `fetch_pc`=RESET_PC, `occ`=`outstanding`=`discard`=0; outputs `imem_req_valid`=0, `ins_valid`=0, `pc_changed`=0, `ins_data`/`ins_pc`=0.
- Issue: `imem_req_valid` = !`redirect_valid` && (`occ` + `outstanding` + `discard` − deq) < DEPTH, where deq = `ins_valid` && `ins_ready`. `imem_req_addr`=`fetch_pc`.
- Accept (valid && ready): `fetch_pc` += 4 (mod 2^32, wraps 32'hFFFF_FFFC → 0), `outstanding`++, `pc_changed`=1 next cycle.
- Response: if `discard`>0, drop it and decrement `discard`; else push {`imem_rsp_data`, PC tag} into FIFO, `outstanding`--. PC tag comes from a parallel PC FIFO written at accept time (or an `expect_pc` register incremented per push).
- Dequeue: FIFO head drives `ins_data`/`ins_pc`; `ins_valid` = `occ`≠0.
- Redirect: `fetch_pc`←{`redirect_pc`[31:2],2'b00}; FIFO emptied; `discard`←`discard`+`outstanding` − (response arriving this cycle); `outstanding`←0; `pc_changed`=1 next cycle.
- Simultaneous events:
  - Redirect + `ins_ready` handshake: the handshake completes (decode keeps that instruction), then flush.
  - Redirect + response: the response is discarded.
  - Redirect + request: the request is suppressed (`imem_req_valid` low).
  - Full FIFO with `ins_ready` low: `imem_req_valid` stays low; no response is ever lost.
- A reset asserted mid-operation returns all state to reset values in the next cycle. The memory side is reset on the same `rst`, so there is no stale-response handling across reset.

## Timing
- First request: the cycle after `rst` samples 1, with addr=RESET_PC.
- Latency: response in cycle n → `ins_valid` in cycle n+1 (registered FIFO, no bypass).
- Throughput: with 1-cycle memory, DEPTH=2 and `ins_ready` held high, one instruction per cycle sustained after a 2-cycle fill.
- Redirect in cycle n: FIFO empty and new request at `redirect_pc` in cycle n+1; first new `ins_valid` no earlier than n+3.
- Combinational paths: `redirect_valid`→`imem_req_valid`, and `ins_ready`→`imem_req_valid`. No path from `imem_rsp_*` to any output.

## Structure
- Package `rv32_fetch_pkg`: `XLEN`=32, `INSN_BYTES`=4, default `RESET_PC`, and a `fetch_entry_t` struct {insn[31:0], pc[31:0]}.
- One sub-module `fetch_fifo`, parameterised by DEPTH, carrying `fetch_entry_t`: synchronous flush, push/pop, `occ` output. Credit, discard and PC logic live in `fetch_unit`.

## Test plan
- Reset, 1-cycle memory returning addr-derived words, `ins_ready`=1 → PCs 0,4,8,… delivered one per cycle from cycle 3; `ins_pc`/`ins_data` match.
- `ins_ready`=0 for 10 cycles → exactly DEPTH requests accepted, `imem_req_valid` low afterwards; on release, all instructions delivered in order with none dropped.
- 3-cycle memory latency with 2 requests in flight, then `redirect_pc`=32'h0000_0103 → both stale responses dropped; next `ins_pc`=32'h0000_0100.
- Redirect in the same cycle as an `ins_ready` handshake and a response → the handshaked instruction is consumed, the response is dropped, and the FIFO is empty next cycle.
- Redirect to 32'hFFFF_FFF8 → fetches at FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted while 2 requests are outstanding → next cycle `ins_valid`=0, `outstanding`=0, and a new request is issued at RESET_PC.

Source files
------------

// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch stage.
//   XLEN             : architectural register / address width
//   INSN_BYTES       : bytes per instruction word (fetch PC stride)
//   DEFAULT_RESET_PC : default first fetch address after reset
//   fetch_entry_t    : one buffered fetch result {insn, pc}
//   next_pc/align_pc : sequential PC step and word alignment helpers
package rv32_fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INSN_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] insn;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Sequential fetch step; wraps naturally at 2^XLEN.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSN_BYTES);
  endfunction

  // Instructions are word aligned, so the low two address bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetch results between instruction memory and decode.
// Registered: an entry pushed in cycle n is visible at the head in n+1.
//   clk        : rising-edge clock
//   rst        : synchronous active-low reset (pointers and occupancy only)
//   flush      : synchronous empty; takes priority over push/pop
//   push       : write push_entry at the tail (ignored when full)
//   push_entry : {insn, pc} to store
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry, meaningful only when occ != 0
//   occ        : number of valid entries, 0..DEPTH
module fetch_fifo
  import rv32_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);

  fetch_entry_t  slots [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop && (occ != '0);
  assign do_push = push && ((occ != CW'(DEPTH)) || do_pop);

  // Control: pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      occ <= occ + CW'(do_push) - CW'(do_pop);
    end
  end

  // Data: storage is not reset; occ qualifies what is readable
  always_ff @(posedge clk) begin
    if (do_push && !flush) slots[wr_ptr] <= push_entry;
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage for the RV32IM core.
// Owns the fetch PC, issues word requests to instruction memory, buffers the
// in-order responses and hands {insn, pc} pairs to decode. A redirect from
// execute reloads the PC, flushes the buffer and arranges for responses still
// in flight to be dropped when they return.
//   clk            : rising-edge clock
//   rst            : synchronous active-low reset
//   imem_req_valid : request valid (combinational from credit, redirect, rst)
//   imem_req_ready : memory accepts the request
//   imem_req_addr  : word-aligned fetch address (the fetch PC)
//   imem_rsp_valid : in-order response, never back-pressured
//   imem_rsp_data  : fetched instruction word
//   redirect_valid : execute redirects fetch this cycle
//   redirect_pc    : new fetch PC (low two bits ignored)
//   ins_valid      : instruction available to decode
//   ins_ready      : decode consumes the instruction
//   ins_data       : instruction word (zero when nothing is valid)
//   ins_pc         : address of ins_data (zero when nothing is valid)
//   pc_changed     : one-cycle pulse after the fetch PC register updates
module fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ins_valid,
  input  logic            ins_ready,
  output logic [XLEN-1:0] ins_data,
  output logic [XLEN-1:0] ins_pc,
  output logic            pc_changed
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] expect_pc;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic            pc_changed_q;

  logic            deq;
  logic            accept;
  logic            rsp_stale;
  logic            rsp_keep;
  logic            push;
  logic [CW+1:0]   inflight;
  logic [CW+1:0]   credit_limit;
  logic            credit_ok;

  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Credit: every buffered, outstanding or to-be-discarded fetch holds a
  // slot. A same-cycle dequeue frees one slot early, which is what gives
  // one-per-cycle throughput at DEPTH=2 with single-cycle memory.
  assign deq          = ins_valid && ins_ready;
  assign inflight     = (CW+2)'(occ) + (CW+2)'(outstanding) + (CW+2)'(discard);
  assign credit_limit = (CW+2)'(DEPTH) + (CW+2)'(deq);
  assign credit_ok    = inflight < credit_limit;

  // Holding off while rst is asserted keeps the request quiet in reset.
  assign imem_req_valid = rst && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // Responses owed to a pre-redirect stream are consumed by discard first.
  assign rsp_stale = imem_rsp_valid && (discard != '0);
  assign rsp_keep  = imem_rsp_valid && (discard == '0);
  assign push      = rsp_keep && !redirect_valid;

  assign push_entry.insn = imem_rsp_data;
  assign push_entry.pc   = expect_pc;

  // Stage boundary: memory response -> instruction buffer
  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (deq),
    .head       (head),
    .occ        (occ)
  );

  // Fetch PC, response PC tag, credit and discard bookkeeping.
  // On redirect the in-flight count moves wholesale into discard, minus a
  // response that lands in the same cycle (it is dropped right here).
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc     <= RESET_PC;
      expect_pc    <= RESET_PC;
      outstanding  <= '0;
      discard      <= '0;
      pc_changed_q <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc     <= align_pc(redirect_pc);
      expect_pc    <= align_pc(redirect_pc);
      outstanding  <= '0;
      discard      <= discard + outstanding - CW'(imem_rsp_valid);
      pc_changed_q <= 1'b1;
    end else begin
      if (accept) fetch_pc  <= next_pc(fetch_pc);
      if (push)   expect_pc <= next_pc(expect_pc);
      outstanding  <= outstanding + CW'(accept) - CW'(rsp_keep);
      if (rsp_stale) discard <= discard - CW'(1);
      pc_changed_q <= accept;
    end
  end

  // Stage boundary: instruction buffer head -> decode
  assign ins_valid  = (occ != '0);
  assign ins_data   = ins_valid ? head.insn : '0;
  assign ins_pc     = ins_valid ? head.pc   : '0;
  assign pc_changed = pc_changed_q;

endmodule
